// File: rtl/scan_chain_pkg.sv
// ============================================================================
// scan_chain_pkg : register map, bit indices and FSM states for scan_chain_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

package scan_chain_pkg;

    localparam logic [4:0] OFF_DATA_IN  = 5'h00;
    localparam logic [4:0] OFF_DATA_OUT = 5'h04;
    localparam logic [4:0] OFF_LENGTH   = 5'h08;
    localparam logic [4:0] OFF_CTRL     = 5'h0C;
    localparam logic [4:0] OFF_STATUS   = 5'h10;

    localparam int CTRL_START_BIT  = 0;
    localparam int CTRL_IE_BIT     = 1;
    localparam int STATUS_DONE_BIT = 0;
    localparam int STATUS_IDLE_BIT = 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [5:0] MAX_LEN = 6'd32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } scan_state_t;

    function automatic logic [5:0] clamp_len(input logic [5:0] len);
        return (len > MAX_LEN) ? MAX_LEN : len;
    endfunction

    // Ones in bit positions below n; used to clear stale capture bits at start.
    function automatic logic [31:0] low_mask(input logic [5:0] n);
        if (n >= MAX_LEN) begin
            return '1;
        end
        return (32'd1 << n) - 32'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/scan_shift_engine.sv
// ============================================================================
// scan_shift_engine : FSM, clock divider, bit counter and scan capture
// Rev 1.0
// ============================================================================
`default_nettype none

module scan_shift_engine
    import scan_chain_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        start,
    input  logic [31:0] data_in,
    input  logic [5:0]  length,
    input  logic        scan_output,
    output logic        scan_enable,
    output logic        scan_ck_enable,
    output logic        scan_input,
    output logic        idle,
    output logic        done_pulse,
    output logic [31:0] data_out
);

    localparam logic [7:0] C_DIV_LAST = 8'(CLK_DIV - 1);

    scan_state_t r_state;
    scan_state_t w_state_next;

    logic [7:0]  r_div;
    logic [4:0]  r_bitcnt;
    logic [5:0]  r_n;
    logic [31:0] r_shreg;
    logic [31:0] r_data_out;
    logic [5:0]  w_len_clamped;
    logic        w_tick;
    logic        w_last_bit;

    assign w_len_clamped = clamp_len(length);
    assign w_tick        = (r_state == SHIFT) && (r_div == C_DIV_LAST);
    assign w_last_bit    = ({1'b0, r_bitcnt} == (r_n - 6'd1));
    assign data_out      = r_data_out;

    always_ff @(posedge aclk or posedge aresetn) begin
        if (aresetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        scan_enable    = 1'b0;
        scan_ck_enable = 1'b0;
        scan_input     = 1'b0;
        idle           = 1'b0;
        done_pulse     = 1'b0;
        case (r_state)
            IDLE: begin
                idle = 1'b1;
                if (start) begin
                    w_state_next = (w_len_clamped == 6'd0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                scan_enable    = 1'b1;
                scan_input     = r_shreg[r_bitcnt];
                scan_ck_enable = w_tick;
                if (w_tick && w_last_bit) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                done_pulse   = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Latched copies decouple the running shift from register writes.
    always_ff @(posedge aclk or posedge aresetn) begin
        if (aresetn) begin
            r_div      <= '0;
            r_bitcnt   <= '0;
            r_n        <= '0;
            r_shreg    <= '0;
            r_data_out <= '0;
        end else if ((r_state == IDLE) && start) begin
            r_div      <= '0;
            r_bitcnt   <= '0;
            r_n        <= w_len_clamped;
            r_shreg    <= data_in;
            r_data_out <= r_data_out & low_mask(w_len_clamped);
        end else if (r_state == SHIFT) begin
            if (w_tick) begin
                r_div                <= '0;
                r_data_out[r_bitcnt] <= scan_output;
                r_bitcnt             <= r_bitcnt + 5'd1;
            end else begin
                r_div <= r_div + 8'd1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/scan_chain_ctrl.sv
// ============================================================================
// scan_chain_ctrl : AXI4-Lite register block driving the scan shift engine
// Rev 1.0
// ============================================================================
`default_nettype none

module scan_chain_ctrl
    import scan_chain_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic [ADDR_W-1:0]   s_awaddr,
    input  logic                s_awvalid,
    output logic                s_awready,
    input  logic [DATA_W-1:0]   s_wdata,
    input  logic [DATA_W/8-1:0] s_wstrb,
    input  logic                s_wvalid,
    output logic                s_wready,
    output logic [1:0]          s_bresp,
    output logic                s_bvalid,
    input  logic                s_bready,
    input  logic [ADDR_W-1:0]   s_araddr,
    input  logic                s_arvalid,
    output logic                s_arready,
    output logic [DATA_W-1:0]   s_rdata,
    output logic [1:0]          s_rresp,
    output logic                s_rvalid,
    input  logic                s_rready,
    output logic                scan_enable,
    output logic                scan_ck_enable,
    output logic                scan_input,
    input  logic                scan_output,
    output logic                irq
);

    logic                r_aw_full;
    logic [2:0]          r_aw_idx;
    logic                r_w_full;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W/8-1:0] r_wstrb;
    logic                r_bvalid;
    logic [1:0]          r_bresp;
    logic                r_rvalid;
    logic [DATA_W-1:0]   r_rdata;
    logic [1:0]          r_rresp;

    logic [DATA_W-1:0]   r_data_in;
    logic [5:0]          r_length;
    logic                r_start;
    logic                r_ie;
    logic                r_done;

    logic [4:0]          w_wr_off;
    logic [4:0]          w_rd_off;
    logic                w_wr_fire;
    logic                w_start;
    logic                w_w1c;
    logic                w_eng_idle;
    logic                w_eng_done;
    logic [31:0]         w_data_out;
    logic [DATA_W-1:0]   w_rd_data;
    logic [1:0]          w_rd_resp;
    logic                w_unused_addr;

    assign w_unused_addr = ^{s_awaddr[ADDR_W-1:5], s_awaddr[1:0],
                             s_araddr[ADDR_W-1:5], s_araddr[1:0]};

    assign s_awready = !r_aw_full;
    assign s_wready  = !r_w_full;
    assign s_bvalid  = r_bvalid;
    assign s_bresp   = r_bresp;
    assign s_arready = !r_rvalid;
    assign s_rvalid  = r_rvalid;
    assign s_rdata   = r_rdata;
    assign s_rresp   = r_rresp;
    assign irq       = r_done & r_ie;

    assign w_wr_off  = {r_aw_idx, 2'b00};
    assign w_rd_off  = {s_araddr[4:2], 2'b00};
    assign w_wr_fire = r_aw_full && r_w_full && !r_bvalid;

    // Only a 0->1 edge of the stored start bit launches a shift, and only when idle.
    assign w_start = w_wr_fire && (w_wr_off == OFF_CTRL) && r_wstrb[0]
                     && r_wdata[CTRL_START_BIT] && !r_start && w_eng_idle;
    assign w_w1c   = w_wr_fire && (w_wr_off == OFF_STATUS) && r_wstrb[0]
                     && r_wdata[STATUS_DONE_BIT];

    always_ff @(posedge aclk or posedge aresetn) begin
        if (aresetn) begin
            r_aw_full <= 1'b0;
            r_aw_idx  <= '0;
            r_w_full  <= 1'b0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
        end else begin
            if (s_awvalid && !r_aw_full) begin
                r_aw_full <= 1'b1;
                r_aw_idx  <= s_awaddr[4:2];
            end
            if (s_wvalid && !r_w_full) begin
                r_w_full <= 1'b1;
                r_wdata  <= s_wdata;
                r_wstrb  <= s_wstrb;
            end
            if (w_wr_fire) begin
                r_bvalid <= 1'b1;
                r_bresp  <= (w_wr_off <= OFF_STATUS) ? RESP_OKAY : RESP_SLVERR;
            end else if (r_bvalid && s_bready) begin
                r_bvalid  <= 1'b0;
                r_aw_full <= 1'b0;
                r_w_full  <= 1'b0;
            end
        end
    end

    always_ff @(posedge aclk or posedge aresetn) begin
        if (aresetn) begin
            r_data_in <= '0;
            r_length  <= '0;
            r_start   <= 1'b0;
            r_ie      <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            if (w_wr_fire) begin
                case (w_wr_off)
                    OFF_DATA_IN: begin
                        for (int b = 0; b < DATA_W / 8; b++) begin
                            if (r_wstrb[b]) begin
                                r_data_in[b*8 +: 8] <= r_wdata[b*8 +: 8];
                            end
                        end
                    end
                    OFF_LENGTH: begin
                        if (r_wstrb[0]) begin
                            r_length <= r_wdata[5:0];
                        end
                    end
                    OFF_CTRL: begin
                        if (r_wstrb[0]) begin
                            r_start <= r_wdata[CTRL_START_BIT];
                            r_ie    <= r_wdata[CTRL_IE_BIT];
                        end
                    end
                    default: ;
                endcase
            end
            // A completing shift outranks a simultaneous software clear.
            if (w_eng_done) begin
                r_done <= 1'b1;
            end else if (w_start || w_w1c) begin
                r_done <= 1'b0;
            end
        end
    end

    always_comb begin
        w_rd_data = '0;
        w_rd_resp = RESP_OKAY;
        case (w_rd_off)
            OFF_DATA_IN:  w_rd_data = r_data_in;
            OFF_DATA_OUT: w_rd_data = w_data_out;
            OFF_LENGTH:   w_rd_data[5:0] = r_length;
            OFF_CTRL: begin
                w_rd_data[CTRL_START_BIT] = r_start;
                w_rd_data[CTRL_IE_BIT]    = r_ie;
            end
            OFF_STATUS: begin
                w_rd_data[STATUS_DONE_BIT] = r_done;
                w_rd_data[STATUS_IDLE_BIT] = w_eng_idle;
            end
            default: w_rd_resp = RESP_SLVERR;
        endcase
    end

    always_ff @(posedge aclk or posedge aresetn) begin
        if (aresetn) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rresp  <= RESP_OKAY;
        end else if (s_arvalid && !r_rvalid) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rd_data;
            r_rresp  <= w_rd_resp;
        end else if (r_rvalid && s_rready) begin
            r_rvalid <= 1'b0;
        end
    end

    scan_shift_engine #(
        .CLK_DIV (CLK_DIV)
    ) u_engine (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .start          (w_start),
        .data_in        (r_data_in),
        .length         (r_length),
        .scan_output    (scan_output),
        .scan_enable    (scan_enable),
        .scan_ck_enable (scan_ck_enable),
        .scan_input     (scan_input),
        .idle           (w_eng_idle),
        .done_pulse     (w_eng_done),
        .data_out       (w_data_out)
    );

endmodule

`default_nettype wire

// File: tb/tb_scan_chain_ctrl.sv
// ============================================================================
// tb_scan_chain_ctrl : directed bench with an 8-bit loopback chain model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_scan_chain_ctrl;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [31:0] s_awaddr;
    logic        s_awvalid;
    logic        s_awready;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_wvalid;
    logic        s_wready;
    logic [1:0]  s_bresp;
    logic        s_bvalid;
    logic        s_bready;
    logic [31:0] s_araddr;
    logic        s_arvalid;
    logic        s_arready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rvalid;
    logic        s_rready;
    logic        scan_enable;
    logic        scan_ck_enable;
    logic        scan_input;
    wire         scan_output;
    logic        irq;

    logic        tie1;
    logic [7:0]  chain = '0;
    logic [31:0] sh_log = '0;
    int          cyc = 0;
    int          pulses = 0;
    int          en_cycles = 0;
    int          space_err = 0;
    int          en_rise = 0;
    int          irq_rise = 0;
    int          last_pulse = 0;
    logic        have_last = 1'b0;
    logic        prev_en = 1'b0;
    logic        prev_irq = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 aclk = ~aclk;

    scan_chain_ctrl #(
        .CLK_DIV (4),
        .ADDR_W  (32),
        .DATA_W  (32)
    ) dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .s_awaddr       (s_awaddr),
        .s_awvalid      (s_awvalid),
        .s_awready      (s_awready),
        .s_wdata        (s_wdata),
        .s_wstrb        (s_wstrb),
        .s_wvalid       (s_wvalid),
        .s_wready       (s_wready),
        .s_bresp        (s_bresp),
        .s_bvalid       (s_bvalid),
        .s_bready       (s_bready),
        .s_araddr       (s_araddr),
        .s_arvalid      (s_arvalid),
        .s_arready      (s_arready),
        .s_rdata        (s_rdata),
        .s_rresp        (s_rresp),
        .s_rvalid       (s_rvalid),
        .s_rready       (s_rready),
        .scan_enable    (scan_enable),
        .scan_ck_enable (scan_ck_enable),
        .scan_input     (scan_input),
        .scan_output    (scan_output),
        .irq            (irq)
    );

    // 8-bit chain: shifts in at bit0, presents bit7 as scan_output.
    assign scan_output = tie1 | chain[7];
    always @(posedge aclk) begin
        cyc <= cyc + 1;
        if (scan_ck_enable) chain <= {chain[6:0], scan_input};
    end

    always @(negedge aclk) begin
        prev_en  <= scan_enable;
        prev_irq <= irq;
        if (scan_enable && !prev_en) begin
            en_rise   <= cyc;
            have_last <= 1'b0;
        end
        if (scan_enable) en_cycles <= en_cycles + 1;
        if (scan_ck_enable) begin
            pulses     <= pulses + 1;
            sh_log     <= {scan_input, sh_log[31:1]};
            if (have_last && (cyc - last_pulse != 4)) space_err <= space_err + 1;
            last_pulse <= cyc;
            have_last  <= 1'b1;
        end
        if (irq && !prev_irq) irq_rise <= cyc;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, output logic [1:0] resp);
        logic aw_ok, w_ok, b_ok, a_hs, d_hs;
        aw_ok = 1'b0; w_ok = 1'b0; b_ok = 1'b0; resp = 2'b11;
        s_awaddr = addr; s_awvalid = 1'b1;
        s_wdata = data; s_wstrb = 4'hF; s_wvalid = 1'b1; s_bready = 1'b1;
        for (int t = 0; t < 20 && !(aw_ok && w_ok); t++) begin
            @(negedge aclk);
            a_hs = s_awvalid && s_awready;
            d_hs = s_wvalid && s_wready;
            @(posedge aclk); #1;
            if (a_hs) begin s_awvalid = 1'b0; aw_ok = 1'b1; end
            if (d_hs) begin s_wvalid = 1'b0; w_ok = 1'b1; end
        end
        for (int t = 0; t < 20 && !b_ok; t++) begin
            @(negedge aclk);
            if (s_bvalid) begin b_ok = 1'b1; resp = s_bresp; end
            @(posedge aclk); #1;
        end
        s_awvalid = 1'b0; s_wvalid = 1'b0; s_bready = 1'b0;
        check("axi_write_complete", 32'(aw_ok && w_ok && b_ok), 32'd1);
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
        logic a_ok, r_ok;
        a_ok = 1'b0; r_ok = 1'b0; data = 32'hDEAD_BEEF; resp = 2'b11;
        s_araddr = addr; s_arvalid = 1'b1; s_rready = 1'b1;
        for (int t = 0; t < 20 && !a_ok; t++) begin
            @(negedge aclk);
            a_ok = s_arready;
            @(posedge aclk); #1;
        end
        s_arvalid = 1'b0;
        for (int t = 0; t < 20 && !r_ok; t++) begin
            @(negedge aclk);
            if (s_rvalid) begin r_ok = 1'b1; data = s_rdata; resp = s_rresp; end
            @(posedge aclk); #1;
        end
        s_rready = 1'b0;
        check("axi_read_complete", 32'(a_ok && r_ok), 32'd1);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        logic [1:0] r;
        axi_write(addr, data, r);
    endtask

    task automatic wait_idle();
        logic [31:0] d;
        logic [1:0]  r;
        logic        ok;
        ok = 1'b0;
        for (int t = 0; t < 100 && !ok; t++) begin
            axi_read(32'h4_4A00_010, d, r);
            if (d[1]) ok = 1'b1;
        end
        check("idle_reached", 32'(ok), 32'd1);
    endtask

    logic [31:0] rd;
    logic [1:0]  rsp;
    int          p0, e0, s0;

    initial begin
        tie1 = 1'b0;
        aresetn = 1'b1;
        s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0;
        s_bready = 1'b0; s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b0;
        repeat (10) @(posedge aclk);
        #1;
        check("rst_scan_enable", 32'(scan_enable), 32'd0);
        check("rst_bvalid", 32'(s_bvalid), 32'd0);
        check("rst_rvalid", 32'(s_rvalid), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        aresetn = 1'b0;
        @(posedge aclk); #1;

        axi_read(32'h44A0_0010, rd, rsp);
        check("rst_status", rd, 32'h2);
        check("rst_status_resp", 32'(rsp), 32'd0);
        axi_read(32'h44A0_0004, rd, rsp);
        check("rst_data_out", rd, 32'h0);

        // Loopback pass 1: load chain with 0xA5.
        wr(32'h44A0_0000, 32'hA5);
        wr(32'h44A0_0008, 32'd8);
        p0 = pulses; e0 = en_cycles; s0 = space_err;
        wr(32'h44A0_000C, 32'h3);
        wait_idle();
        check("lb1_pulses", 32'(pulses - p0), 32'd8);
        check("lb1_spacing", 32'(space_err - s0), 32'd0);
        check("lb1_enable_cycles", 32'(en_cycles - e0), 32'd32);
        check("lb1_busy_cycles", 32'(irq_rise - en_rise), 32'd33);
        check("lb1_shifted_bits", 32'(sh_log[31:24]), 32'hA5);

        // Loopback pass 2: read the 0xA5 back out of the chain.
        wr(32'h44A0_0000, 32'h0);
        wr(32'h44A0_000C, 32'h2);
        wr(32'h44A0_000C, 32'h3);
        wait_idle();
        axi_read(32'h44A0_0004, rd, rsp);
        check("lb2_data_out", rd, 32'hA5);
        axi_read(32'h44A0_0010, rd, rsp);
        check("lb2_status", rd, 32'h3);
        check("lb2_irq", 32'(irq), 32'd1);

        // Length clamps to 32 with scan_output tied high.
        tie1 = 1'b1;
        wr(32'h44A0_0008, 32'd40);
        wr(32'h44A0_000C, 32'h2);
        p0 = pulses;
        wr(32'h44A0_000C, 32'h3);
        wait_idle();
        check("full_pulses", 32'(pulses - p0), 32'd32);
        axi_read(32'h44A0_0004, rd, rsp);
        check("full_data_out", rd, 32'hFFFF_FFFF);
        axi_read(32'h44A0_0008, rd, rsp);
        check("length_readback", rd, 32'd40);

        // Zero length: straight to DONE, no pulses, DATA_OUT cleared.
        wr(32'h44A0_0008, 32'd0);
        wr(32'h44A0_000C, 32'h2);
        p0 = pulses;
        wr(32'h44A0_000C, 32'h3);
        check("zero_len_irq", 32'(irq), 32'd1);
        check("zero_len_pulses", 32'(pulses - p0), 32'd0);
        axi_read(32'h44A0_0004, rd, rsp);
        check("zero_len_data_out", rd, 32'h0);

        // Busy rules: DATA_IN rewrite and restart attempt during SHIFT.
        tie1 = 1'b0;
        wr(32'h44A0_0000, 32'h3C);
        wr(32'h44A0_0008, 32'd8);
        wr(32'h44A0_000C, 32'h2);
        p0 = pulses;
        wr(32'h44A0_000C, 32'h3);
        wr(32'h44A0_0000, 32'h1234);
        wr(32'h44A0_000C, 32'h2);
        wr(32'h44A0_000C, 32'h3);
        wait_idle();
        check("busy_pulses", 32'(pulses - p0), 32'd8);
        check("busy_shifted_bits", 32'(sh_log[31:24]), 32'h3C);
        axi_read(32'h44A0_0000, rd, rsp);
        check("busy_data_in", rd, 32'h1234);

        // W ahead of AW, byte strobes, and BREADY back-pressure.
        s_wdata = 32'hCAFE_0000; s_wstrb = 4'b1100; s_wvalid = 1'b1; s_bready = 1'b0;
        @(posedge aclk); #1;
        s_wvalid = 1'b0;
        repeat (4) @(posedge aclk);
        #1;
        check("early_w_wready", 32'(s_wready), 32'd0);
        check("early_w_bvalid", 32'(s_bvalid), 32'd0);
        s_awaddr = 32'h44A0_0000; s_awvalid = 1'b1;
        @(posedge aclk); #1;
        s_awvalid = 1'b0;
        @(posedge aclk); #1;
        check("bvalid_rise", 32'(s_bvalid), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(posedge aclk); #1;
            check("bvalid_hold", 32'(s_bvalid), 32'd1);
        end
        s_bready = 1'b1;
        @(posedge aclk); #1;
        s_bready = 1'b0;
        check("bvalid_drop", 32'(s_bvalid), 32'd0);
        repeat (3) @(posedge aclk);
        #1;
        check("single_b", 32'(s_bvalid), 32'd0);
        axi_read(32'h44A0_0000, rd, rsp);
        check("wstrb_merge", rd, 32'hCAFE_1234);

        // Unmapped offsets.
        axi_read(32'h44A0_0014, rd, rsp);
        check("bad_read_resp", 32'(rsp), 32'd2);
        check("bad_read_data", rd, 32'h0);
        axi_write(32'h44A0_0018, 32'hFFFF_FFFF, rsp);
        check("bad_write_resp", 32'(rsp), 32'd2);

        // W1C of done and irq gating by ie.
        wr(32'h44A0_0010, 32'h1);
        axi_read(32'h44A0_0010, rd, rsp);
        check("w1c_status", rd, 32'h2);
        check("w1c_irq", 32'(irq), 32'd0);
        wr(32'h44A0_000C, 32'h0);
        wr(32'h44A0_0008, 32'd0);
        wr(32'h44A0_000C, 32'h1);
        check("irq_ie_off", 32'(irq), 32'd0);
        axi_read(32'h44A0_0010, rd, rsp);
        check("done_ie_off", rd, 32'h3);
        wr(32'h44A0_000C, 32'h3);
        check("irq_ie_on", 32'(irq), 32'd1);

        // Reset in the middle of a shift.
        wr(32'h44A0_0000, 32'h55);
        wr(32'h44A0_0008, 32'd8);
        wr(32'h44A0_000C, 32'h2);
        p0 = pulses;
        wr(32'h44A0_000C, 32'h3);
        for (int t = 0; t < 200 && (pulses - p0) < 3; t++) @(negedge aclk);
        #1;
        check("pre_reset_pulses", 32'(pulses - p0), 32'd3);
        check("pre_reset_enable", 32'(scan_enable), 32'd1);
        aresetn = 1'b1;
        #1;
        check("async_reset_enable", 32'(scan_enable), 32'd0);
        check("async_reset_ck", 32'(scan_ck_enable), 32'd0);
        repeat (3) @(posedge aclk);
        #1;
        aresetn = 1'b0;
        @(posedge aclk); #1;
        axi_read(32'h44A0_0010, rd, rsp);
        check("post_reset_status", rd, 32'h2);
        axi_read(32'h44A0_0004, rd, rsp);
        check("post_reset_data_out", rd, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not reach its end");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/scan_chain_ctrl.md
Name: scan_chain_ctrl

Overview:
- AXI4-Lite slave register block plus scan shift engine. Software-side responder to the AXI-Lite master agent in the scan IP bench.
- Software loads a data word and a bit count, then starts a shift. The block drives scan_enable, scan_ck_enable and scan_input into the design-under-snapshot scan chain.
- It captures scan_output into a readback register, giving save/restore of flop state through the chain.
- Sits behind the PS/VIP AXI interconnect at base 0x44A0_0000.

Parameters:
- CLK_DIV, 4: aclk cycles per scan clock pulse; legal range 1..255.
- ADDR_W, 32: AXI address width; only addr[4:2] is decoded.
- DATA_W, 32: AXI data width; fixed at 32.

Ports:
- aclk  in  1  system clock
- aresetn  in  1  reset: aresetn, asynchronous, active-high; clock aclk
- s_awaddr/s_awvalid/s_awready  in/in/out  ADDR_W/1/1  write address channel
- s_wdata/s_wstrb/s_wvalid/s_wready  in/in/in/out  32/4/1/1  write data channel
- s_bresp/s_bvalid/s_bready  out/out/in  2/1/1  write response channel
- s_araddr/s_arvalid/s_arready  in/in/out  ADDR_W/1/1  read address channel
- s_rdata/s_rresp/s_rvalid/s_rready  out/out/out/in  32/2/1/1  read data channel
- scan_enable  out  1  chain in shift mode
- scan_ck_enable  out  1  one-cycle shift strobe
- scan_input  out  1  serial data into chain
- scan_output  in  1  serial data from chain
- irq  out  1  level; equals STATUS.done AND CTRL.ie

Behaviour:
- Reset: all ready/valid low, bresp/rresp 0, rdata 0, all registers 0, FSM IDLE, scan_* and irq low.
- Register map (byte offset):
  - 0x00 DATA_IN (RW).
  - 0x04 DATA_OUT (RO).
  - 0x08 LENGTH (RW, [5:0]).
  - 0x0C CTRL (RW): bit0 start, bit1 ie.
  - 0x10 STATUS: bit0 done (W1C), bit1 idle (RO).
  - Other offsets: read returns 0 with SLVERR; write has no effect and responds SLVERR.
- Write channel:
  - AW and W are captured independently, each ready high while its holding slot is empty.
  - BVALID is asserted the cycle after both slots are full, and the register update occurs in that same cycle.
  - BVALID holds until BREADY; slots free on the B handshake. Only one write is outstanding.
  - wstrb is honoured per byte.
- Read channel:
  - ARREADY is high when RVALID is low.
  - RVALID is asserted the cycle after the AR handshake and holds, with data stable, until RREADY.
- Start trigger:
  - CTRL.start is level storage; a shift starts on its 0->1 write transition while FSM is IDLE.
  - A start transition while busy is ignored, with OKAY response.
  - Starting clears STATUS.done.
- FSM IDLE -> SHIFT -> DONE -> IDLE:
  - On start, shreg <= DATA_IN, bitcnt <= 0, n <= min(LENGTH, 32).
  - n = 0 goes directly to DONE.
- SHIFT:
  - scan_enable = 1; divider counts 0..CLK_DIV-1.
  - On the cycle where the divider equals CLK_DIV-1: scan_ck_enable = 1, scan_input = shreg[bitcnt], DATA_OUT[bitcnt] <= scan_output, bitcnt++.
  - Leave SHIFT after the pulse where bitcnt reaches n-1.
  - scan_input holds shreg[bitcnt] throughout SHIFT; it is 0 outside SHIFT.
- DATA_OUT bits >= n are cleared at start.
- DONE: one cycle, scan_enable = 0, sets STATUS.done; then IDLE.
- Latency: first scan_ck_enable occurs CLK_DIV cycles after SHIFT entry. Total busy time = n*CLK_DIV + 1 cycles.
- Writes to DATA_IN/LENGTH during SHIFT update the registers only; the active shift uses its latched copies.
- STATUS.idle = 1 only in IDLE.
- A W1C of done in the same cycle as the DONE set: set wins.
- Reset mid-shift aborts immediately: scan_enable and scan_ck_enable drop asynchronously, chain contents are undefined, DATA_OUT = 0.

Decomposition:
- Package scan_chain_pkg holds:
  - Register offset constants: OFF_DATA_IN, OFF_DATA_OUT, OFF_LENGTH, OFF_CTRL, OFF_STATUS.
  - CTRL/STATUS bit indices.
  - AXI resp constants: RESP_OKAY, RESP_SLVERR.
  - typedef enum scan_state_t {IDLE, SHIFT, DONE}.
- One sub-module, scan_shift_engine: FSM, divider, bit counter and capture.
- The top contains the AXI-Lite slave and register file.

Test Plan:
- Reset/defaults: assert aresetn for 10 cycles. Read 0x10 -> 0x00000002 OKAY; read 0x04 -> 0; scan_enable = 0.
- Loopback through an 8-bit bench chain (shift at bit0, output bit7), CLK_DIV = 4.
  - Write DATA_IN = 0xA5, LENGTH = 8, CTRL = 1, then poll idle.
  - Expect exactly 8 scan_ck_enable pulses spaced 4 cycles apart, and 33 busy cycles.
  - Write DATA_IN = 0, CTRL = 0 then 1. DATA_OUT -> 0x000000A5 and done = 1.
- Full width: LENGTH = 40 clamps to 32 pulses.
  - With scan_output tied 1, DATA_OUT = 0xFFFFFFFF.
  - LENGTH = 0 -> no pulses, done = 1 within 2 cycles.
- Busy rules:
  - Write DATA_IN = 0x1234 mid-shift: shifted bits still reflect the old value; DATA_IN reads 0x1234.
  - A second start during SHIFT does not restart; the pulse count is unchanged.
- AXI corner cases:
  - W presented 5 cycles before AW -> single B. BREADY held low 3 cycles -> BVALID stays high.
  - Read 0x14 -> SLVERR, data 0.
  - Write STATUS = 1 clears done; irq follows ie.
- Reset mid-shift: assert aresetn after 3 pulses -> scan_enable low the same cycle; post-reset STATUS = 0x2, DATA_OUT = 0.
